// File: rtl/pc_unit_pkg.sv
// Shared CPU definitions for the program-counter slice: address width,
// default reset vector and the next-PC source select encoding.
package pc_unit_pkg;

   localparam int ADDR_W = 8;

   localparam logic [ADDR_W-1:0] RESET_VEC_DEF = 8'h00;

   // Next-PC source select
   typedef logic [1:0] pc_src_t;
   localparam pc_src_t SRC_HOLD = 2'd0;
   localparam pc_src_t SRC_INC  = 2'd1;
   localparam pc_src_t SRC_TGT  = 2'd2;
   localparam pc_src_t SRC_POP  = 2'd3;

   // Modulo-256 address increment; the carry out is deliberately dropped
   function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
      return a + {{(ADDR_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/pc_unit_ret_stack.sv
// Return-address LIFO for pc_unit (built only with RET_STACK_EN).
// Stack pointer sp counts entries 0..DEPTH; overflow and underflow leave sp
// and storage untouched and set a sticky error flag. pop wins over push.
module ret_stack
   import pc_unit_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] din,
   output logic [ADDR_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic              err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int SP_W  = IDX_W + 1;

   logic [ADDR_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] mem_d [DEPTH];
   logic [SP_W-1:0]   sp_q;
   logic [SP_W-1:0]   sp_d;
   logic              err_q;
   logic              err_d;
   logic [IDX_W-1:0]  top_idx_s;

   assign full      = (sp_q == SP_W'(DEPTH));
   assign empty     = (sp_q == {SP_W{1'b0}});
   assign top_idx_s = IDX_W'(sp_q - {{(SP_W-1){1'b0}}, 1'b1});
   assign dout      = empty ? {ADDR_W{1'b0}} : mem_q[top_idx_s];
   assign err       = err_q;

   // Next stack contents, pointer and sticky error from push/pop requests
   always_comb begin
      mem_d = mem_q;
      sp_d  = sp_q;
      err_d = err_q;
      if (pop) begin
         if (empty) begin
            err_d = 1'b1;
         end else begin
            sp_d = sp_q - {{(SP_W-1){1'b0}}, 1'b1};
         end
      end else if (push) begin
         if (full) begin
            err_d = 1'b1;
         end else begin
            mem_d[sp_q[IDX_W-1:0]] = din;
            sp_d = sp_q + {{(SP_W-1){1'b0}}, 1'b1};
         end
      end else begin
         sp_d = sp_q;
      end
   end

   // Stack state registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {ADDR_W{1'b0}};
         end
         sp_q  <= {SP_W{1'b0}};
         err_q <= 1'b0;
      end else begin
         mem_q <= mem_d;
         sp_q  <= sp_d;
         err_q <= err_d;
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Program counter for the Simple CPU v1: select mux plus register.
// Priority: ret > call > jmp > (br & zero) > inc > hold; en=0 stalls everything.
// Optional macro RET_STACK_EN adds the hardware return-address stack; without
// it call acts as jmp, ret is ignored, stk_err=0 and stk_empty=1.
module pc_unit
   import pc_unit_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_VEC = RESET_VEC_DEF,
   parameter int                STK_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              inc,
   input  logic              jmp,
   input  logic              br,
   input  logic              zero,
   input  logic [ADDR_W-1:0] tgt,
   input  logic              call,
   input  logic              ret,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_nxt,
   output logic              wrap,
   output logic              stk_err,
   output logic              stk_empty
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic              wrap_q;
   logic              wrap_d;
   logic [ADDR_W-1:0] pc_inc_s;
   pc_src_t           src_s;

   assign pc_inc_s = addr_inc(pc_q);

`ifdef RET_STACK_EN
   logic              push_s;
   logic              pop_s;
   logic [ADDR_W-1:0] stk_dout_s;
   logic              stk_full_s;
   logic              stk_empty_s;
   logic              stk_err_s;

   ret_stack #(
      .DEPTH (STK_DEPTH)
   ) u_ret_stack (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .pop   (pop_s),
      .din   (pc_inc_s),
      .dout  (stk_dout_s),
      .full  (stk_full_s),
      .empty (stk_empty_s),
      .err   (stk_err_s)
   );

   assign stk_err   = stk_err_s;
   assign stk_empty = stk_empty_s;

   // Request decode to next-PC source and stack push/pop strobes
   always_comb begin
      src_s  = SRC_HOLD;
      push_s = 1'b0;
      pop_s  = 1'b0;
      if (!en) begin
         src_s = SRC_HOLD;
      end else if (ret) begin
         // Underflow keeps the PC where it is; the stack flags the error
         pop_s = 1'b1;
         src_s = stk_empty_s ? SRC_HOLD : SRC_POP;
      end else if (call) begin
         // Overflow drops the push inside the stack but the jump still happens
         push_s = 1'b1;
         src_s  = SRC_TGT;
      end else if (jmp) begin
         src_s = SRC_TGT;
      end else if (br && zero) begin
         src_s = SRC_TGT;
      end else if (inc) begin
         src_s = SRC_INC;
      end else begin
         src_s = SRC_HOLD;
      end
   end
`else
   logic unused_s;

   // ret and the stack depth have no function without the return stack
   assign unused_s  = ret | (STK_DEPTH == 0);
   assign stk_err   = 1'b0;
   assign stk_empty = 1'b1;

   // Request decode to next-PC source; call is a plain jump here
   always_comb begin
      src_s = SRC_HOLD;
      if (!en) begin
         src_s = SRC_HOLD;
      end else if (jmp || call) begin
         src_s = SRC_TGT;
      end else if (br && zero) begin
         src_s = SRC_TGT;
      end else if (inc) begin
         src_s = SRC_INC;
      end else begin
         src_s = SRC_HOLD;
      end
   end
`endif

   // Next-PC mux and sticky wrap detection (only a real increment wraps)
   always_comb begin
      pc_d   = pc_q;
      wrap_d = wrap_q;
      case (src_s)
         SRC_HOLD: pc_d = pc_q;
         SRC_INC:  pc_d = pc_inc_s;
         SRC_TGT:  pc_d = tgt;
`ifdef RET_STACK_EN
         SRC_POP:  pc_d = stk_dout_s;
`endif
         default:  pc_d = pc_q;
      endcase
      if ((src_s == SRC_INC) && (pc_q == {ADDR_W{1'b1}})) begin
         wrap_d = 1'b1;
      end else begin
         wrap_d = wrap_q;
      end
   end

   // PC and wrap registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q   <= RESET_VEC;
         wrap_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         wrap_q <= wrap_d;
      end
   end

   assign pc     = pc_q;
   assign pc_nxt = pc_d;
   assign wrap   = wrap_q;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter register for the Simple CPU v1; drives the `pc` operand consumed by MUX A and the instruction-memory address.
- Holds an 8-bit PC and updates it once per enabled clock by increment, absolute jump, or conditional branch on the zero flag.
- Optionally includes a small hardware return-address stack for call/return.

Parameters:
- RESET_VEC, 8'h00, PC value loaded on reset.
- STK_DEPTH, 4, return-stack entries (power of 2, 2..8); used only when RET_STACK_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global advance enable; 0 = hold PC and stack (stall).
- inc  in  1  request PC+1.
- jmp  in  1  request unconditional load of tgt.
- br  in  1  request branch to tgt if zero=1.
- zero  in  1  ALU/accumulator zero flag, sampled same cycle as br.
- tgt  in  8  jump/branch/call target address.
- call  in  1  push return address and jump to tgt (optional feature).
- ret  in  1  pop return address into PC (optional feature).
- pc  out  8  current PC (registered); feeds MUX A and imem address.
- pc_nxt  out  8  combinational next-PC value (what pc becomes at the next enabled edge).
- wrap  out  1  sticky: set when an increment wraps 8'hFF->8'h00.
- stk_err  out  1  sticky: push when full or pop when empty.
- stk_empty  out  1  stack holds zero entries.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low. On assertion: pc=RESET_VEC, wrap=0, stk_err=0, stack pointer=0, stk_empty=1.
- State updates only on a rising clk edge with en=1. With en=0, all state holds and pc_nxt=pc.
- Next-PC priority, highest first:
  - ret: pops the top of stack.
  - call: pushes pc+1 and loads tgt.
  - jmp: loads tgt.
  - br with zero=1: loads tgt.
  - inc: loads pc+1.
  - none of the above: hold.
- br with zero=0 is treated as inc if inc=1, otherwise hold.
- Latency: a request presented in cycle N appears on pc in cycle N+1. pc_nxt reflects it in cycle N.
- Arithmetic is mod 256. An increment from 8'hFF gives 8'h00 and sets wrap.
  - wrap clears only on reset.
  - A jmp to 8'h00 does not set wrap.
  - The pushed return address pc+1 at pc=8'hFF is 8'h00 and does not set wrap.
- Stack (when compiled in) is LIFO with pointer sp of 0..STK_DEPTH.
  - Push when sp=STK_DEPTH: the entry is discarded, sp is unchanged, stk_err sets, and the jump to tgt still happens.
  - Pop when sp=0: PC holds, stk_err sets, sp stays 0.
  - call and ret both high: ret wins and call is ignored. No simultaneous push and pop.
- Reset mid-operation clears everything immediately, independent of clk.
- No X propagation: undefined request combinations resolve by the priority list.

Optional Feature:
- Macro: RET_STACK_EN.
- Defined: the return stack, call/ret handling and stk_err/stk_empty logic are built as described above.
- Undefined:
  - call behaves exactly as jmp (no push).
  - ret is ignored.
  - stk_err is tied 0 and stk_empty is tied 1.
  - No stack storage is inferred.

Decomposition:
- Shared package/include (cpu_defs): ADDR_W=8, RESET_VEC default, and named localparams for the next-PC source select (SRC_HOLD, SRC_INC, SRC_TGT, SRC_POP).
- Natural sub-module: ret_stack, a STK_DEPTH x 8 LIFO.
  - Inputs: push, pop, din.
  - Outputs: dout, full, empty, err.
  - Instantiated only under RET_STACK_EN.
  - Keeps the pc_unit top as a select mux plus register.

Test Plan:
- Reset then inc=1 for 3 enabled cycles -> pc 00,01,02,03; pc_nxt leads pc by one cycle. Assert rst_n=0 asynchronously mid-clock -> pc=00 immediately.
- pc=8'hFE, inc=1 for 2 cycles -> pc FF then 00, wrap=1 and stays 1 after a jmp to 8'h40.
- jmp=1, br=1, inc=1, tgt=8'h80 at pc=8'h10 -> pc=80. Then br=1, zero=0, inc=1 -> pc=81. Then br=1, zero=1, tgt=8'h20 -> pc=20. Then en=0 with inc=1 -> pc holds 20.
- (RET_STACK_EN) At pc=8'h05, call with tgt=8'h30 -> pc=30, stk_empty=0. Then ret -> pc=06, stk_empty=1. Then ret again -> pc holds 06, stk_err=1.
- (RET_STACK_EN, STK_DEPTH=4) 5 nested calls -> 5th jumps but does not push, stk_err=1. Then 4 rets return the first 4 addresses in LIFO order.
- (RET_STACK_EN undefined) call with tgt=8'h55 -> pc=55. ret ignored -> pc holds or increments per inc. stk_err=0.
